stopwatch_ctrl: RTL and testbench

Control sequencer for the stopwatch. It consumes the one-cycle tick strobes and the blink level produced by the clock divider, debounces three raw push-buttons, and runs the IDLE/RUN/PAUSE/LAP state machine. It maintains the mm:ss BCD time count and presents either the live or the lap-frozen value to the seven-segment display driver, with blanking during pause.

---
 rtl/stopwatch_ctrl_if.sv | 28 ++
 rtl/stopwatch_ctrl.sv | 158 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch control sequencer and its environment:
// tick strobes, blink level and raw buttons in, BCD digits and status out.
interface stopwatch_ctrl_if;
    logic       sec_tick;
    logic       deb_tick;
    logic       blink_clk;
    logic       btn_start;
    logic       btn_lap;
    logic       btn_clear;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       digit_en;
    logic       running;
    logic       lap_active;
    logic       ovf;

    modport master (
        output sec_tick, deb_tick, blink_clk, btn_start, btn_lap, btn_clear,
        input  min_tens, min_ones, sec_tens, sec_ones, digit_en, running, lap_active, ovf
    );

    modport slave (
        input  sec_tick, deb_tick, blink_clk, btn_start, btn_lap, btn_clear,
        output min_tens, min_ones, sec_tens, sec_ones, digit_en, running, lap_active, ovf
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button debounce, IDLE/RUN/PAUSE/LAP state machine,
// mm:ss BCD counter with lap capture, and registered display outputs.
module stopwatch_ctrl #(
    parameter int unsigned DEB_SAMPLES = 3
) (
    input logic            clk,
    input logic            rst,
    stopwatch_ctrl_if.slave sw
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

    // Button index: 0 = start, 1 = lap, 2 = clear
    logic [2:0]                  raw;
    logic [2:0][DEB_SAMPLES-1:0] hist;
    logic [2:0]                  stable;
    logic [2:0]                  stable_d;
    logic [2:0]                  ev;

    state_t     state, next_state;
    logic       do_lap, do_clr;
    logic [3:0] s1, s10, m1, m10;
    logic [3:0] s1_n, s10_n, m1_n, m10_n;
    logic       wrap;
    logic [3:0] lap_s1, lap_s10, lap_m1, lap_m10;
    logic       ovf_q;
    logic       counting;

    assign raw = {sw.btn_clear, sw.btn_lap, sw.btn_start};

    always_ff @(posedge clk) begin
        if (rst) begin
            hist     <= '0;
            stable   <= '0;
            stable_d <= '0;
            ev       <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (sw.deb_tick)
                    hist[i] <= {hist[i][DEB_SAMPLES-2:0], raw[i]};
                if (&hist[i])
                    stable[i] <= 1'b1;
                else if (~|hist[i])
                    stable[i] <= 1'b0;
            end
            stable_d <= stable;
            ev       <= stable & ~stable_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Priority clr > start > lap; only the first event legal in this state acts.
    always_comb begin
        next_state = state;
        do_lap     = 1'b0;
        do_clr     = 1'b0;
        case (state)
            IDLE: begin
                if (ev[0]) next_state = RUN;
            end
            RUN: begin
                if (ev[0]) begin
                    next_state = PAUSE;
                end else if (ev[1]) begin
                    next_state = LAP;
                    do_lap     = 1'b1;
                end
            end
            PAUSE: begin
                if (ev[2]) begin
                    next_state = IDLE;
                    do_clr     = 1'b1;
                end else if (ev[0]) begin
                    next_state = RUN;
                end
            end
            LAP: begin
                if (ev[0])      next_state = PAUSE;
                else if (ev[1]) next_state = RUN;
            end
            default: next_state = IDLE;
        endcase
    end

    assign counting = (state == RUN) || (state == LAP);

    always_comb begin
        s1_n  = s1;
        s10_n = s10;
        m1_n  = m1;
        m10_n = m10;
        wrap  = 1'b0;
        if (s1 != 4'd9) begin
            s1_n = s1 + 4'd1;
        end else begin
            s1_n = '0;
            if (s10 != 4'd5) begin
                s10_n = s10 + 4'd1;
            end else begin
                s10_n = '0;
                if (m1 != 4'd9) begin
                    m1_n = m1 + 4'd1;
                end else begin
                    m1_n = '0;
                    if (m10 != 4'd5) begin
                        m10_n = m10 + 4'd1;
                    end else begin
                        m10_n = '0;
                        wrap  = 1'b1;
                    end
                end
            end
        end
    end

    // Lap capture samples the pre-increment count when coincident with a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            {m10, m1, s10, s1}                 <= '0;
            {lap_m10, lap_m1, lap_s10, lap_s1} <= '0;
            ovf_q                              <= 1'b0;
        end else begin
            if (do_clr) begin
                {m10, m1, s10, s1} <= '0;
                ovf_q              <= 1'b0;
            end else if (counting && sw.sec_tick) begin
                {m10, m1, s10, s1} <= {m10_n, m1_n, s10_n, s1_n};
                if (wrap) ovf_q <= 1'b1;
            end
            if (do_lap)
                {lap_m10, lap_m1, lap_s10, lap_s1} <= {m10, m1, s10, s1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones} <= '0;
            sw.digit_en   <= 1'b1;
            sw.running    <= 1'b0;
            sw.lap_active <= 1'b0;
            sw.ovf        <= 1'b0;
        end else begin
            if (state == LAP)
                {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones} <= {lap_m10, lap_m1, lap_s10, lap_s1};
            else
                {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones} <= {m10, m1, s10, s1};
            sw.digit_en   <= (state == PAUSE) ? sw.blink_clk : 1'b1;
            sw.running    <= counting;
            sw.lap_active <= (state == LAP);
            sw.ovf        <= ovf_q;
        end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with DEB_SAMPLES = 3.
module tb_stopwatch_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    stopwatch_ctrl_if sw();

    stopwatch_ctrl #(.DEB_SAMPLES(3)) dut (
        .clk(clk),
        .rst(rst),
        .sw (sw.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Hold the given buttons for 5 samples, release for 5 samples, then settle.
    task automatic press(input logic s, input logic l, input logic c);
        sw.deb_tick = 1'b1;
        sw.btn_start = s; sw.btn_lap = l; sw.btn_clear = c;
        idle(5);
        sw.btn_start = 1'b0; sw.btn_lap = 1'b0; sw.btn_clear = 1'b0;
        idle(5);
        sw.deb_tick = 1'b0;
        idle(4);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            sw.sec_tick = 1'b1;
            cycle();
        end
        sw.sec_tick = 1'b0;
        idle(2);
    endtask

    function automatic logic [15:0] digits();
        return {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (digits() !== 16'h0000) begin n_err++; $display("FAIL reset_digits got %h want 0000", digits()); end
        n_cmp++; if ({sw.digit_en, sw.running, sw.lap_active, sw.ovf} !== 4'b1000) begin n_err++;
            $display("FAIL reset_flags got %b want 1000", {sw.digit_en, sw.running, sw.lap_active, sw.ovf}); end
    endtask

    task automatic test_start_count();
        press(1'b1, 1'b0, 1'b0);
        n_cmp++; if (sw.running !== 1'b1) begin n_err++; $display("FAIL start_running got %b want 1", sw.running); end
        ticks(75);
        n_cmp++; if (digits() !== 16'h0115) begin n_err++; $display("FAIL count_75 got %h want 0115", digits()); end
        n_cmp++; if (sw.digit_en !== 1'b1) begin n_err++; $display("FAIL run_digit_en got %b want 1", sw.digit_en); end
    endtask

    task automatic test_pause_clear();
        press(1'b1, 1'b0, 1'b0);
        n_cmp++; if (sw.running !== 1'b0) begin n_err++; $display("FAIL pause_running got %b want 0", sw.running); end
        ticks(3);
        n_cmp++; if (digits() !== 16'h0115) begin n_err++; $display("FAIL pause_frozen got %h want 0115", digits()); end
        sw.blink_clk = 1'b0;
        idle(2);
        n_cmp++; if (sw.digit_en !== 1'b0) begin n_err++; $display("FAIL pause_blink_lo got %b want 0", sw.digit_en); end
        sw.blink_clk = 1'b1;
        idle(2);
        n_cmp++; if (sw.digit_en !== 1'b1) begin n_err++; $display("FAIL pause_blink_hi got %b want 1", sw.digit_en); end
        sw.blink_clk = 1'b0;
        press(1'b0, 1'b0, 1'b1);
        n_cmp++; if (digits() !== 16'h0000) begin n_err++; $display("FAIL clear_digits got %h want 0000", digits()); end
        n_cmp++; if ({sw.digit_en, sw.running} !== 2'b10) begin n_err++;
            $display("FAIL clear_flags got %b want 10", {sw.digit_en, sw.running}); end
    endtask

    task automatic test_lap();
        press(1'b1, 1'b0, 1'b0);
        ticks(10);
        press(1'b0, 1'b1, 1'b0);
        ticks(5);
        n_cmp++; if (digits() !== 16'h0010) begin n_err++; $display("FAIL lap_frozen got %h want 0010", digits()); end
        n_cmp++; if ({sw.lap_active, sw.running} !== 2'b11) begin n_err++;
            $display("FAIL lap_flags got %b want 11", {sw.lap_active, sw.running}); end
        press(1'b0, 1'b1, 1'b0);
        n_cmp++; if (digits() !== 16'h0015) begin n_err++; $display("FAIL lap_release got %h want 0015", digits()); end
        n_cmp++; if (sw.lap_active !== 1'b0) begin n_err++; $display("FAIL lap_exit got %b want 0", sw.lap_active); end
    endtask

    task automatic test_wrap();
        ticks(3584);
        n_cmp++; if (digits() !== 16'h5959) begin n_err++; $display("FAIL wrap_max got %h want 5959", digits()); end
        n_cmp++; if (sw.ovf !== 1'b0) begin n_err++; $display("FAIL wrap_pre_ovf got %b want 0", sw.ovf); end
        ticks(1);
        n_cmp++; if (digits() !== 16'h0000) begin n_err++; $display("FAIL wrap_zero got %h want 0000", digits()); end
        n_cmp++; if (sw.ovf !== 1'b1) begin n_err++; $display("FAIL wrap_ovf got %b want 1", sw.ovf); end
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        ticks(1);
        n_cmp++; if ({digits(), sw.ovf} !== {16'h0001, 1'b1}) begin n_err++;
            $display("FAIL wrap_resume got %h/%b want 0001/1", digits(), sw.ovf); end
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        n_cmp++; if ({digits(), sw.ovf} !== {16'h0000, 1'b0}) begin n_err++;
            $display("FAIL wrap_clear got %h/%b want 0000/0", digits(), sw.ovf); end
    endtask

    task automatic test_debounce_priority();
        sw.deb_tick = 1'b1;
        sw.btn_start = 1'b1;
        idle(2);
        sw.btn_start = 1'b0;
        idle(5);
        sw.deb_tick = 1'b0;
        idle(4);
        n_cmp++; if (sw.running !== 1'b0) begin n_err++; $display("FAIL glitch_running got %b want 0", sw.running); end
        press(1'b1, 1'b0, 1'b0);
        ticks(7);
        press(1'b1, 1'b0, 1'b0);
        n_cmp++; if (digits() !== 16'h0007) begin n_err++; $display("FAIL prio_paused got %h want 0007", digits()); end
        press(1'b1, 1'b0, 1'b1);
        n_cmp++; if ({digits(), sw.running} !== {16'h0000, 1'b0}) begin n_err++;
            $display("FAIL prio_clr_over_start got %h/%b want 0000/0", digits(), sw.running); end
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        n_cmp++; if ({sw.running, sw.lap_active, sw.digit_en} !== 3'b000) begin n_err++;
            $display("FAIL prio_start_over_lap got %b want 000", {sw.running, sw.lap_active, sw.digit_en}); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        ticks(200);
        press(1'b0, 1'b1, 1'b0);
        n_cmp++; if ({digits(), sw.lap_active} !== {16'h0320, 1'b1}) begin n_err++;
            $display("FAIL mid_lap got %h/%b want 0320/1", digits(), sw.lap_active); end
        sw.deb_tick = 1'b1;
        sw.btn_start = 1'b1;
        idle(2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_cmp++; if ({digits(), sw.ovf, sw.running, sw.lap_active, sw.digit_en} !== {16'h0000, 4'b0001}) begin n_err++;
            $display("FAIL mid_reset got %h/%b want 0000/0001", digits(), {sw.ovf, sw.running, sw.lap_active, sw.digit_en}); end
        cycle();
        sw.btn_start = 1'b0;
        idle(5);
        sw.deb_tick = 1'b0;
        idle(6);
        n_cmp++; if (sw.running !== 1'b0) begin n_err++; $display("FAIL mid_no_event got %b want 0", sw.running); end
        press(1'b1, 1'b0, 1'b0);
        n_cmp++; if (sw.running !== 1'b1) begin n_err++; $display("FAIL mid_fresh_press got %b want 1", sw.running); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        sw.sec_tick = 1'b0;
        sw.deb_tick = 1'b0;
        sw.blink_clk = 1'b0;
        sw.btn_start = 1'b0;
        sw.btn_lap = 1'b0;
        sw.btn_clear = 1'b0;
        test_reset();
        test_start_count();
        test_pause_clear();
        test_lap();
        test_wrap();
        test_debounce_priority();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
